// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding read, small {pc, word} buffer toward decode, redirect/flush handling.
// Optional misaligned-redirect trap is enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = 12,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_valid_in,
  input  logic [31:0]       mem_data_in,
  output logic              instr_valid_out,
  input  logic              instr_ready_in,
  output logic [31:0]       instr_out,
  output logic [31:0]       pc_out,
  input  logic              redirect_in,
  input  logic [31:0]       redirect_pc_in,
  output logic              fetch_misalign_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLUSH} state_t;

  // Handshake: a head entry moves to decode on any rising edge where
  // instr_valid_out && instr_ready_in; valid never depends on ready.
  state_t              state_q, state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                misalign_q, misalign_d;
  logic [31:0]         buf_pc_q   [FIFO_DEPTH];
  logic [31:0]         buf_word_q [FIFO_DEPTH];
  logic                push;
  logic                pop;

  assign instr_valid_out    = (count_q != '0);
  assign instr_out          = instr_valid_out ? buf_word_q[rd_ptr_q] : 32'h0;
  assign pc_out             = instr_valid_out ? buf_pc_q[rd_ptr_q]   : 32'h0;
  assign mem_req_out        = mem_req_q;
  assign mem_addr_out       = mem_addr_q;
  assign fetch_misalign_out = misalign_q;
  assign pop                = instr_valid_out && instr_ready_in;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    push       = 1'b0;

    if (redirect_in) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      fetch_pc_d = redirect_pc_in;
      misalign_d = |redirect_pc_in[1:0];
`else
      fetch_pc_d = redirect_pc_in & 32'hFFFF_FFFC;
`endif
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      case (state_q)
        ST_WAIT:  state_d = mem_valid_in ? ST_IDLE : ST_FLUSH;
        // A response landing in the same cycle still retires the FLUSH, otherwise we would wait forever.
        ST_FLUSH: state_d = mem_valid_in ? ST_IDLE : ST_FLUSH;
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((count_q < CNT_W'(FIFO_DEPTH)) && !misalign_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q[ADDR_W+1:2];
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_valid_in) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (mem_valid_in) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      if (push) begin
        buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
        buf_word_q[wr_ptr_q] <= mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a latency-programmable memory responder plus
// linear stimulus steps with hand-computed expectations.
module tb_ifetch_unit;

  localparam int ADDR_W = 12;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_valid_in;
  logic [31:0]       mem_data_in;
  logic              instr_valid_out;
  logic              instr_ready_in;
  logic [31:0]       instr_out;
  logic [31:0]       pc_out;
  logic              redirect_in;
  logic [31:0]       redirect_pc_in;
  logic              fetch_misalign_out;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;
  int n_req;

  ifetch_unit dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .mem_req_out        (mem_req_out),
    .mem_addr_out       (mem_addr_out),
    .mem_valid_in       (mem_valid_in),
    .mem_data_in        (mem_data_in),
    .instr_valid_out    (instr_valid_out),
    .instr_ready_in     (instr_ready_in),
    .instr_out          (instr_out),
    .pc_out             (pc_out),
    .redirect_in        (redirect_in),
    .redirect_pc_in     (redirect_pc_in),
    .fetch_misalign_out (fetch_misalign_out)
  );

  always #5 clk_in = ~clk_in;

  // Memory responder: word at address a is {20'hC0DE0, a}; response is
  // presented mem_lat-1 cycles after the cycle in which mem_req_out is high.
  logic              mem_pend = 1'b0;
  int                mem_cnt = 0;
  logic [ADDR_W-1:0] mem_a = '0;
  always @(negedge clk_in) begin
    mem_valid_in = 1'b0;
    if (rst_in) begin
      mem_pend = 1'b0;
    end else begin
      if (mem_req_out) begin
        mem_pend = 1'b1;
        mem_cnt  = mem_lat;
        mem_a    = mem_addr_out;
      end
      if (mem_pend) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          mem_valid_in = 1'b1;
          mem_data_in  = {20'hC0DE0, mem_a};
          mem_pend     = 1'b0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst_in      = 1'b1;
    redirect_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in         = 1'b1;
    mem_valid_in   = 1'b0;
    mem_data_in    = 32'h0;
    instr_ready_in = 1'b1;
    redirect_in    = 1'b0;
    redirect_pc_in = 32'h0;

    // Streaming at latency 1
    mem_lat = 1;
    do_reset();
    chk1 ("rst_req",      mem_req_out, 1'b0);
    chk32("rst_addr",     {20'h0, mem_addr_out}, 32'h0);
    chk1 ("rst_valid",    instr_valid_out, 1'b0);
    chk32("rst_instr",    instr_out, 32'h0);
    chk32("rst_pc",       pc_out, 32'h0);
    chk1 ("rst_misalign", fetch_misalign_out, 1'b0);
    tick();
    chk1 ("s_req0",   mem_req_out, 1'b1);
    chk32("s_addr0",  {20'h0, mem_addr_out}, 32'h0);
    tick();
    chk1 ("s_valid0", instr_valid_out, 1'b1);
    chk32("s_pc0",    pc_out, 32'h0);
    chk32("s_ins0",   instr_out, 32'hC0DE_0000);
    chk1 ("s_noreq",  mem_req_out, 1'b0);
    tick();
    chk1 ("s_req1",   mem_req_out, 1'b1);
    chk32("s_addr1",  {20'h0, mem_addr_out}, 32'h1);
    chk1 ("s_gap",    instr_valid_out, 1'b0);
    tick();
    chk32("s_pc1",    pc_out, 32'h4);
    chk32("s_ins1",   instr_out, 32'hC0DE_0001);
    tick();
    chk32("s_addr2",  {20'h0, mem_addr_out}, 32'h2);
    tick();
    chk1 ("s_valid2", instr_valid_out, 1'b1);
    chk32("s_pc2",    pc_out, 32'h8);
    chk32("s_ins2",   instr_out, 32'hC0DE_0002);

    // Back-pressure: buffer fills with two words, then fetch stops
    instr_ready_in = 1'b0;
    do_reset();
    n_req = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (mem_req_out) n_req++;
    end
    chk32("bp_nreq",  n_req, 32'd2);
    chk1 ("bp_valid", instr_valid_out, 1'b1);
    chk32("bp_pc0",   pc_out, 32'h0);
    chk32("bp_ins0",  instr_out, 32'hC0DE_0000);
    instr_ready_in = 1'b1;
    tick();
    chk32("bp_pc1",   pc_out, 32'h4);
    chk32("bp_ins1",  instr_out, 32'hC0DE_0001);
    chk1 ("bp_noreq", mem_req_out, 1'b0);
    tick();
    chk1 ("bp_req",   mem_req_out, 1'b1);
    chk32("bp_addr",  {20'h0, mem_addr_out}, 32'h2);
    chk1 ("bp_empty", instr_valid_out, 1'b0);

    // Redirect during WAIT at latency 3: late response must be flushed
    mem_lat = 3;
    do_reset();
    tick();
    chk1("fl_req0", mem_req_out, 1'b1);
    tick();
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0100;
    tick();
    redirect_in = 1'b0;
    chk1("fl_noreq0", mem_req_out, 1'b0);
    chk1("fl_empty0", instr_valid_out, 1'b0);
    tick();
    chk1("fl_noreq1", mem_req_out, 1'b0);
    chk1("fl_empty1", instr_valid_out, 1'b0);
    tick();
    chk1 ("fl_req1",  mem_req_out, 1'b1);
    chk32("fl_addr1", {20'h0, mem_addr_out}, 32'h40);
    chk1 ("fl_empty2", instr_valid_out, 1'b0);
    tick();
    tick();
    tick();
    chk1 ("fl_valid", instr_valid_out, 1'b1);
    chk32("fl_pc",    pc_out, 32'h0000_0100);
    chk32("fl_ins",   instr_out, 32'hC0DE_0040);

    // Redirect coinciding with the response: drop data, no FLUSH
    mem_lat = 1;
    do_reset();
    tick();
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0200;
    tick();
    redirect_in = 1'b0;
    chk1("co_noreq", mem_req_out, 1'b0);
    chk1("co_empty", instr_valid_out, 1'b0);
    tick();
    chk1 ("co_req",  mem_req_out, 1'b1);
    chk32("co_addr", {20'h0, mem_addr_out}, 32'h80);
    tick();
    chk1 ("co_valid", instr_valid_out, 1'b1);
    chk32("co_pc",    pc_out, 32'h0000_0200);
    chk32("co_ins",   instr_out, 32'hC0DE_0080);

    // Misaligned redirect from a full buffer
    instr_ready_in = 1'b0;
    do_reset();
    repeat (4) tick();
    chk1("ma_full", instr_valid_out, 1'b1);
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0102;
    tick();
    redirect_in = 1'b0;
    chk1("ma_empty", instr_valid_out, 1'b0);
    chk1("ma_noreq", mem_req_out, 1'b0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk1("ma_flag", fetch_misalign_out, 1'b1);
    n_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_req_out) n_req++;
    end
    chk32("ma_halt", n_req, 32'd0);
    chk1 ("ma_sticky", fetch_misalign_out, 1'b1);
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0104;
    tick();
    redirect_in = 1'b0;
    chk1("ma_clear", fetch_misalign_out, 1'b0);
    tick();
    chk1 ("ma_req",  mem_req_out, 1'b1);
    chk32("ma_addr", {20'h0, mem_addr_out}, 32'h41);
`else
    chk1("ma_flag", fetch_misalign_out, 1'b0);
    tick();
    chk1 ("ma_req",  mem_req_out, 1'b1);
    chk32("ma_addr", {20'h0, mem_addr_out}, 32'h40);
    tick();
    chk1 ("ma_valid", instr_valid_out, 1'b1);
    chk32("ma_pc",    pc_out, 32'h0000_0100);
`endif

    // Reset wins over a same-cycle redirect with a full buffer
    instr_ready_in = 1'b0;
    mem_lat = 1;
    do_reset();
    repeat (4) tick();
    chk1("rr_full", instr_valid_out, 1'b1);
    rst_in         = 1'b1;
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_0300;
    tick();
    chk1 ("rr_valid", instr_valid_out, 1'b0);
    chk1 ("rr_req",   mem_req_out, 1'b0);
    chk32("rr_addr",  {20'h0, mem_addr_out}, 32'h0);
    chk32("rr_pc",    pc_out, 32'h0);
    chk32("rr_ins",   instr_out, 32'h0);
    rst_in      = 1'b0;
    redirect_in = 1'b0;
    tick();
    chk1 ("rr_req0",  mem_req_out, 1'b1);
    chk32("rr_addr0", {20'h0, mem_addr_out}, 32'h0);
    tick();
    chk1 ("rr_valid0", instr_valid_out, 1'b1);
    chk32("rr_pc0",    pc_out, 32'h0);
    chk32("rr_ins0",   instr_out, 32'hC0DE_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch initiator that drives the instruction memory read port and delivers fetched words to the decode stage. It holds the fetch PC and issues one word read at a time, with one outstanding request at most. Returned words go into a small instruction buffer with a valid/ready handshake toward decode. It also handles PC redirects from branches and traps, including responses that are still in flight when the redirect arrives.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
ADDR_W, 12, memory word-address width; mem_addr_out = fetch_pc[ADDR_W+1:2].
FIFO_DEPTH, 2, instruction buffer entries (power of two, at least 2).

Ports:
clk_in  input  1  clock; all logic on the rising edge.
rst_in  input  1  synchronous, active-high reset.
mem_req_out  output  1  one-cycle read request strobe.
mem_addr_out  output  ADDR_W  word address; valid while mem_req_out=1.
mem_valid_in  input  1  response valid; at most one per request, latency of 1 or more cycles.
mem_data_in  input  32  instruction word; sampled when mem_valid_in=1.
instr_valid_out  output  1  buffer head is valid.
instr_ready_in  input  1  decode accepts the head.
instr_out  output  32  head instruction word.
pc_out  output  32  PC of the head instruction.
redirect_in  input  1  one-cycle redirect strobe.
redirect_pc_in  input  32  new fetch PC.
fetch_misalign_out  output  1  misaligned redirect flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - fetch_pc=RESET_PC, state=IDLE, buffer count=0.
  - mem_req_out=0, mem_addr_out=0, instr_valid_out=0, instr_out=0, pc_out=0, fetch_misalign_out=0.
  - Reset overrides every other input in that cycle, including redirect_in and mem_valid_in.
  - Reset during WAIT: the late response is not tracked. Integration keeps the memory in reset with the unit.
- Registered outputs: mem_req_out and mem_addr_out.
- Buffer outputs: instr_out, pc_out and instr_valid_out come combinationally from the buffer head. instr_valid_out = (count != 0).
- Buffer: circular buffer, FIFO_DEPTH entries of {pc, word}, read pointer, write pointer and count.
  - Pop when instr_valid_out && instr_ready_in.
  - Push on an accepted response.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WAIT, FLUSH.
  - IDLE, no redirect, count < FIFO_DEPTH: drive mem_req_out=1 with mem_addr_out=fetch_pc[ADDR_W+1:2] next cycle, go to WAIT. The count check ignores a pop in the same cycle.
  - IDLE, buffer full: no request, stay in IDLE.
  - WAIT, mem_valid_in=1 and no redirect: push {fetch_pc, mem_data_in}, fetch_pc += 4 (wraps modulo 2^32), go to IDLE.
  - WAIT, mem_valid_in=0: mem_req_out=0, stay in WAIT.
  - WAIT, redirect_in=1 and mem_valid_in=0: load fetch_pc, flush buffer, go to FLUSH.
  - WAIT, redirect_in=1 and mem_valid_in=1 in the same cycle: discard the data, load fetch_pc, flush, go to IDLE.
  - FLUSH: discard the next mem_valid_in response, go to IDLE. A redirect here updates fetch_pc only and the state stays FLUSH.
- Redirect, any state:
  - fetch_pc=redirect_pc_in with bits[1:0] forced to 00.
  - count=0 and pointers reset.
  - instr_valid_out=0 in the following cycle.
  - Redirect has priority over a same-cycle pop or push.
- No request is issued in the redirect cycle. The first new request goes out the following cycle.
- Buffer space at response time is guaranteed, because a request is only issued when count < FIFO_DEPTH and only pops can occur while in WAIT.
- Peak throughput: one instruction per 2 cycles at memory latency 1.

Optional Feature:
Macro IFETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc_in[1:0] != 00 sets fetch_misalign_out=1 (sticky), loads fetch_pc unmodified and flushes the buffer.
  - Fetching halts: no requests are issued.
  - The next aligned redirect clears the flag and resumes fetching.
  - An in-flight response is still drained via FLUSH.
- Undefined: bits[1:0] are forced to 00 silently, and fetch_misalign_out is tied to 0.

Test Plan:
- Reset, memory latency 1, instr_ready_in=1 -> requests to word addresses 0,1,2,...; pc_out sequence 0x0,0x4,0x8; instr_out matches memory contents; one instruction every 2 cycles.
- instr_ready_in=0 for 10 cycles -> exactly 2 words buffered, mem_req_out stays 0; on release, pops in order with PCs 0x0 then 0x4, then fetch resumes at 0x8.
- Memory latency 3, redirect_in with PC 0x100 in the 2nd wait cycle -> late response discarded; next request to word address 0x40; first delivered pc_out=0x100.
- redirect_in and mem_valid_in in the same cycle (redirect PC 0x200) -> data dropped, next request the following cycle at word address 0x80, no FLUSH.
- Redirect with PC 0x102 -> with macro: fetch_misalign_out=1 and no requests until a redirect to 0x104; without macro: fetch starts at 0x100.
- Reset asserted with redirect_in=1 and a full buffer -> next cycle instr_valid_out=0, fetch restarts at RESET_PC.
